// File: rtl/serial_subtractor_pkg.sv
// Shared widths and FSM encoding for the bit-serial subtractor.
package serial_subtractor_pkg;
  localparam int W  = 8;
  localparam int CW = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;
endpackage

// File: rtl/serial_subtractor_bit.sv
// One-bit full subtractor: d = a - b - br_in, with borrow out.
module full_subtractor_bit (
  input  logic a,
  input  logic b,
  input  logic br_in,
  output logic d,
  output logic br_out
);
  assign d      = a ^ b ^ br_in;
  assign br_out = (~a & b) | (~(a ^ b) & br_in);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial 8-bit subtractor, LSB first, one bit per clock through a single
// full subtractor cell; result and borrow are published only on completion.
module serial_subtractor
  import serial_subtractor_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         B_IN,
  input  logic         START,
  output logic         BUSY,
  output logic         DONE,
  output logic [W-1:0] Y,
  output logic         B_OUT
);
  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, res_q, res_d, y_q, y_d;
  logic            br_q, br_d, bout_q, bout_d;
  logic            d_bit, br_nxt;

  full_subtractor_bit u_fsb (
    .a     (a_q[0]),
    .b     (b_q[0]),
    .br_in (br_q),
    .d     (d_bit),
    .br_out(br_nxt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    br_d    = br_q;
    y_d     = y_q;
    bout_d  = bout_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          a_d     = A;
          b_d     = B;
          br_d    = B_IN;
          res_d   = '0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = br_nxt;
        res_d = {d_bit, res_q[W-1:1]};
        cnt_d = cnt_q + 1'b1;
        // Final bit: counter wraps to 0 and the completed word goes out.
        if (cnt_q == CW'(W-1)) begin
          y_d     = {d_bit, res_q[W-1:1]};
          bout_d  = br_nxt;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      y_q     <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      br_q    <= br_d;
      y_q     <= y_d;
      bout_q  <= bout_d;
    end
  end

  assign BUSY  = (state_q == ST_SHIFT);
  assign DONE  = (state_q == ST_DONE);
  assign Y     = y_q;
  assign B_OUT = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: timing, borrow cases, back-to-back, reset abort.
module tb_serial_subtractor;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] A, B;
  logic       B_IN, START;
  logic       BUSY, DONE, B_OUT;
  logic [7:0] Y;
  int checks = 0;
  int failures = 0;

  serial_subtractor dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .B_IN(B_IN), .START(START),
    .BUSY(BUSY), .DONE(DONE), .Y(Y), .B_OUT(B_OUT)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one START, optionally changes A after edge k+chg_at and pulses
  // START after edge k+pls_at, then checks BUSY/DONE timing and the result.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        input logic [7:0] ey, input logic ebo,
                        input int chg_at, input logic [7:0] a_new, input int pls_at,
                        input string tag);
    logic [7:0] y_prev;
    logic       bo_prev;
    @(negedge clk);
    A = a; B = b; B_IN = bin; START = 1'b1;
    y_prev = Y; bo_prev = B_OUT;
    @(posedge clk); #1;
    START = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk({tag, " busy"}, {15'd0, BUSY}, 16'd1);
      chk({tag, " done_lo"}, {15'd0, DONE}, 16'd0);
      chk({tag, " y_hold"}, {7'd0, B_OUT, Y}, {7'd0, bo_prev, y_prev});
      if (i == chg_at) A = a_new;
      START = (i == pls_at);
      @(posedge clk); #1;
    end
    START = 1'b0;
    chk({tag, " busy_end"}, {15'd0, BUSY}, 16'd0);
    chk({tag, " done"}, {15'd0, DONE}, 16'd1);
    chk({tag, " y"}, {8'd0, Y}, {8'd0, ey});
    chk({tag, " bout"}, {15'd0, B_OUT}, {15'd0, ebo});
    @(posedge clk); #1;
    chk({tag, " done_pulse"}, {15'd0, DONE}, 16'd0);
    chk({tag, " y_after"}, {8'd0, Y}, {8'd0, ey});
  endtask

  initial begin
    logic [8:0] ref9;
    logic [7:0] ra, rb;
    logic       rbin;
    rst_n = 1'b0; A = '0; B = '0; B_IN = 1'b0; START = 1'b0;
    #1;
    chk("reset", {5'd0, BUSY, DONE, B_OUT, Y}, 16'd0);
    #12; rst_n = 1'b1;

    run_op(8'h5A, 8'h13, 1'b0, 8'h47, 1'b0, -1, 8'h00, -1, "basic");
    run_op(8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, -1, 8'h00, -1, "edge0");
    run_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 3, 8'hEE, -1, "opchg");
    run_op(8'h20, 8'h05, 1'b0, 8'h1B, 1'b0, -1, 8'h00, 2, "pulse_mid");
    run_op(8'h33, 8'h33, 1'b1, 8'hFF, 1'b1, -1, 8'h00, 7, "pulse_last");
    run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, -1, 8'h00, -1, "underflow");

    // Back-to-back with START held high: DONE every 9th cycle.
    @(negedge clk);
    A = 8'hFF; B = 8'h0F; B_IN = 1'b0; START = 1'b1;
    @(posedge clk); #1;
    for (int op = 0; op < 3; op++) begin
      for (int i = 0; i < 8; i++) begin
        chk("b2b busy", {15'd0, BUSY}, 16'd1);
        chk("b2b done_lo", {15'd0, DONE}, 16'd0);
        @(posedge clk); #1;
      end
      chk("b2b done", {15'd0, DONE}, 16'd1);
      chk("b2b y", {7'd0, B_OUT, Y}, 16'h00F0);
      if (op == 2) START = 1'b0;
      @(posedge clk); #1;
    end
    chk("b2b idle", {14'd0, BUSY, DONE}, 16'd0);

    // Underflow once more so Y/B_OUT are nonzero before the abort.
    run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, -1, 8'h00, -1, "pre_rst");
    @(negedge clk);
    A = 8'h5A; B = 8'h13; B_IN = 1'b0; START = 1'b1;
    @(posedge clk); #1;
    START = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort outs", {5'd0, BUSY, DONE, B_OUT, Y}, 16'd0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("abort no_done", {5'd0, BUSY, DONE, B_OUT, Y}, 16'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    run_op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, -1, 8'h00, -1, "post_rst");

    // Random operands against a 9-bit reference subtraction.
    for (int n = 0; n < 100; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rbin = 1'($urandom_range(0, 1));
      ref9 = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
      run_op(ra, rb, rbin, ref9[7:0], ref9[8], -1, 8'h00, -1, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
